// File: rtl/mem_arb_pkg.sv
// Shared defaults, FSM state encoding and grant encoding for the I/D-cache
// memory arbiter.
package mem_arb_pkg;

   localparam int ADDR_W_DEF = 28;
   localparam int DATA_W_DEF = 128;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SERVE = 2'd1,
      DONE  = 2'd2
   } state_t;

   typedef enum logic {
      GNT_I = 1'b0,
      GNT_D = 1'b1
   } grant_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side and memory-side signals of the arbiter; the slave modport is the
// arbiter's view, the master modport is the view of its surroundings.
interface mem_arbiter_if
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) ();

   logic              ic_read;
   logic [ADDR_W-1:0] ic_addr;
   logic [DATA_W-1:0] ic_rdata;
   logic              ic_ready;

   logic              dc_read;
   logic              dc_write;
   logic [ADDR_W-1:0] dc_addr;
   logic [DATA_W-1:0] dc_wdata;
   logic [DATA_W-1:0] dc_rdata;
   logic              dc_ready;

   logic              mem_read;
   logic              mem_write;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ready;

   modport slave (
      input  ic_read, ic_addr, dc_read, dc_write, dc_addr, dc_wdata,
      input  mem_rdata, mem_ready,
      output ic_rdata, ic_ready, dc_rdata, dc_ready,
      output mem_read, mem_write, mem_addr, mem_wdata
   );

   modport master (
      output ic_read, ic_addr, dc_read, dc_write, dc_addr, dc_wdata,
      output mem_rdata, mem_ready,
      input  ic_rdata, ic_ready, dc_rdata, dc_ready,
      input  mem_read, mem_write, mem_addr, mem_wdata
   );

endinterface

// File: rtl/arb_rr2.sv
// Two-way round-robin picker: a tie goes to whichever side did not win last.
module arb_rr2
   import mem_arb_pkg::*;
(
   input  logic   req_i,
   input  logic   req_d,
   input  grant_t last_grant,
   output grant_t grant
);

   always_comb begin
      grant = GNT_I;
      if (req_i && req_d)
         grant = (last_grant == GNT_I) ? GNT_D : GNT_I;
      else if (req_d)
         grant = GNT_D;
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates I-cache and D-cache block requests onto a single memory port;
// every output comes straight from a flop.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic          clk,
   input  logic          rst,
   mem_arbiter_if.slave  bus
);

   state_t            r_state,      w_state_nxt;
   grant_t            r_last_grant, w_last_grant_nxt;
   grant_t            r_winner,     w_winner_nxt;
   logic              r_mem_read,   w_mem_read_nxt;
   logic              r_mem_write,  w_mem_write_nxt;
   logic [ADDR_W-1:0] r_mem_addr,   w_mem_addr_nxt;
   logic [DATA_W-1:0] r_mem_wdata,  w_mem_wdata_nxt;
   logic [DATA_W-1:0] r_ic_rdata,   w_ic_rdata_nxt;
   logic [DATA_W-1:0] r_dc_rdata,   w_dc_rdata_nxt;
   logic              r_ic_ready,   w_ic_ready_nxt;
   logic              r_dc_ready,   w_dc_ready_nxt;

   logic   w_req_i;
   logic   w_req_d;
   grant_t w_grant;

   assign w_req_i = bus.ic_read;
   assign w_req_d = bus.dc_read | bus.dc_write;

   arb_rr2 u_arb_rr2 (
      .req_i      (w_req_i),
      .req_d      (w_req_d),
      .last_grant (r_last_grant),
      .grant      (w_grant)
   );

   // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state      <= IDLE;
         r_last_grant <= GNT_I;
         r_winner     <= GNT_I;
         r_mem_read   <= 1'b0;
         r_mem_write  <= 1'b0;
         r_mem_addr   <= '0;
         r_mem_wdata  <= '0;
         r_ic_rdata   <= '0;
         r_dc_rdata   <= '0;
         r_ic_ready   <= 1'b0;
         r_dc_ready   <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_last_grant <= w_last_grant_nxt;
         r_winner     <= w_winner_nxt;
         r_mem_read   <= w_mem_read_nxt;
         r_mem_write  <= w_mem_write_nxt;
         r_mem_addr   <= w_mem_addr_nxt;
         r_mem_wdata  <= w_mem_wdata_nxt;
         r_ic_rdata   <= w_ic_rdata_nxt;
         r_dc_rdata   <= w_dc_rdata_nxt;
         r_ic_ready   <= w_ic_ready_nxt;
         r_dc_ready   <= w_dc_ready_nxt;
      end
   end

   // NOTE: every signal gets a default first, so no path can infer a latch.
   always_comb begin
      w_state_nxt      = r_state;
      w_last_grant_nxt = r_last_grant;
      w_winner_nxt     = r_winner;
      w_mem_read_nxt   = r_mem_read;
      w_mem_write_nxt  = r_mem_write;
      w_mem_addr_nxt   = r_mem_addr;
      w_mem_wdata_nxt  = r_mem_wdata;
      w_ic_rdata_nxt   = r_ic_rdata;
      w_dc_rdata_nxt   = r_dc_rdata;
      w_ic_ready_nxt   = 1'b0;
      w_dc_ready_nxt   = 1'b0;

      unique case (r_state)
         IDLE: begin
            w_mem_read_nxt  = 1'b0;
            w_mem_write_nxt = 1'b0;
            if (w_req_i || w_req_d) begin
               w_state_nxt      = SERVE;
               w_winner_nxt     = w_grant;
               w_last_grant_nxt = w_grant;
               if (w_grant == GNT_D) begin
                  w_mem_addr_nxt = bus.dc_addr;
                  // a write-back outranks a simultaneous read from the D side
                  if (bus.dc_write) begin
                     w_mem_write_nxt = 1'b1;
                     w_mem_wdata_nxt = bus.dc_wdata;
                  end else begin
                     w_mem_read_nxt  = 1'b1;
                  end
               end else begin
                  w_mem_addr_nxt = bus.ic_addr;
                  w_mem_read_nxt = 1'b1;
               end
            end
         end
         SERVE: begin
            if (bus.mem_ready) begin
               w_state_nxt     = DONE;
               w_mem_read_nxt  = 1'b0;
               w_mem_write_nxt = 1'b0;
               if (r_winner == GNT_D) begin
                  w_dc_ready_nxt = 1'b1;
                  if (r_mem_read) w_dc_rdata_nxt = bus.mem_rdata;
               end else begin
                  w_ic_ready_nxt = 1'b1;
                  if (r_mem_read) w_ic_rdata_nxt = bus.mem_rdata;
               end
            end
         end
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   assign bus.mem_read  = r_mem_read;
   assign bus.mem_write = r_mem_write;
   assign bus.mem_addr  = r_mem_addr;
   assign bus.mem_wdata = r_mem_wdata;
   assign bus.ic_rdata  = r_ic_rdata;
   assign bus.ic_ready  = r_ic_ready;
   assign bus.dc_rdata  = r_dc_rdata;
   assign bus.dc_ready  = r_dc_ready;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a request driver predicts grant order and
// memory contents, a monitor checks strobes and completions as they appear.
module tb_mem_arbiter;
   import mem_arb_pkg::*;

   localparam int AW = ADDR_W_DEF;
   localparam int DW = DATA_W_DEF;

   logic clk;
   logic rst;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   typedef struct {
      bit            port_d;
      bit            is_write;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] rdata;
   } exp_t;

   exp_t          exp_q[$];
   int            n_vec  = 0;
   int            n_fail = 0;
   logic [DW-1:0] mem_store [logic [AW-1:0]];
   logic [DW-1:0] shadow    [logic [AW-1:0]];
   bit            glitch_all  = 1'b0;
   bit            glitch_rand = 1'b0;
   int            fixed_lat   = -1;
   bit            last_d      = 1'b0;

   task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] pattern(input logic [AW-1:0] a);
      return {4{4'hC, a}};
   endfunction

   // Reference model: round-robin winner order and a flat memory image.
   task automatic push_exp(input bit pd, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] wd);
      exp_t e;
      e.port_d   = pd;
      e.is_write = wr;
      e.addr     = a;
      e.wdata    = wd;
      e.rdata    = '0;
      if (wr) shadow[a] = wd;
      else    e.rdata = shadow.exists(a) ? shadow[a] : pattern(a);
      exp_q.push_back(e);
      last_d = pd;
   endtask

   // Memory responder: random or fixed latency, optional ready glitches when idle.
   bit busy = 1'b0;
   int cnt  = 0;
   always @(negedge clk) begin
      if (bus.mem_read || bus.mem_write) begin
         if (!busy) begin
            busy = 1'b1;
            cnt  = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 5));
         end
         if (cnt == 0) begin
            bus.mem_ready = 1'b1;
            busy          = 1'b0;
            if (bus.mem_write) begin
               mem_store[bus.mem_addr] = bus.mem_wdata;
               bus.mem_rdata = {$urandom, $urandom, $urandom, $urandom};
            end else begin
               bus.mem_rdata = mem_store.exists(bus.mem_addr) ? mem_store[bus.mem_addr]
                                                              : pattern(bus.mem_addr);
            end
         end else begin
            cnt--;
            bus.mem_ready = 1'b0;
         end
      end else begin
         busy          = 1'b0;
         bus.mem_ready = glitch_all || (glitch_rand && ($urandom_range(0, 3) == 0));
         bus.mem_rdata = {$urandom, $urandom, $urandom, $urandom};
      end
   end

   // Monitor: compares each new strobe and each ready pulse against the queue.
   logic [DW-1:0] exp_ic = '0;
   logic [DW-1:0] exp_dc = '0;
   logic [159:0]  cap    = '0;
   bit            prev_strobe = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      logic strobe;
      strobe = bus.mem_read | bus.mem_write;
      if (!rst) begin
         exp_ic = '0;
         exp_dc = '0;
      end
      if (strobe) check("strobe_mutex", 160'(bus.mem_read & bus.mem_write), 160'(0));
      if (strobe && !prev_strobe) begin
         if (exp_q.size() == 0) begin
            check("unexpected_strobe", 160'(strobe), 160'(0));
         end else begin
            e = exp_q[0];
            check("strobe_kind", 160'({bus.mem_read, bus.mem_write}),
                  160'(e.is_write ? 2'b01 : 2'b10));
            check("strobe_addr", 160'(bus.mem_addr), 160'(e.addr));
            if (e.is_write) check("strobe_wdata", 160'(bus.mem_wdata), 160'(e.wdata));
         end
         cap = 160'({bus.mem_read, bus.mem_write, bus.mem_addr, bus.mem_wdata});
      end else if (strobe) begin
         check("strobe_hold", 160'({bus.mem_read, bus.mem_write, bus.mem_addr, bus.mem_wdata}), cap);
      end
      if (bus.ic_ready || bus.dc_ready) begin
         check("ready_mutex", 160'(bus.ic_ready & bus.dc_ready), 160'(0));
         if (exp_q.size() == 0) begin
            check("unexpected_ready", 160'({bus.ic_ready, bus.dc_ready}), 160'(0));
         end else begin
            e = exp_q.pop_front();
            check("ready_port", 160'(bus.dc_ready), 160'(e.port_d));
            if (!e.is_write) begin
               if (e.port_d) exp_dc = e.rdata;
               else          exp_ic = e.rdata;
            end
            check("ic_rdata", 160'(bus.ic_rdata), 160'(exp_ic));
            check("dc_rdata", 160'(bus.dc_rdata), 160'(exp_dc));
         end
      end
      prev_strobe = strobe;
   end

   task automatic check_outputs_zero(input string tag);
      check({tag, "_flags"}, 160'({bus.mem_read, bus.mem_write, bus.ic_ready, bus.dc_ready}), 160'(0));
      check({tag, "_mem_addr"},  160'(bus.mem_addr),  160'(0));
      check({tag, "_mem_wdata"}, 160'(bus.mem_wdata), 160'(0));
      check({tag, "_ic_rdata"},  160'(bus.ic_rdata),  160'(0));
      check({tag, "_dc_rdata"},  160'(bus.dc_rdata),  160'(0));
   endtask

   task automatic drop_all();
      bus.ic_read  = 1'b0;
      bus.dc_read  = 1'b0;
      bus.dc_write = 1'b0;
   endtask

   // Hold rst low over two edges so the monitor sees it unambiguously.
   task automatic apply_reset(input string tag);
      rst = 1'b0;
      drop_all();
      @(negedge clk);
      @(negedge clk);
      exp_q.delete();
      last_d = 1'b0;
      check_outputs_zero(tag);
      rst = 1'b1;
   endtask

   task automatic issue(input bit wi, input bit wd, input bit drd, input bit dwr,
                        input logic [AW-1:0] ia, input logic [AW-1:0] da,
                        input logic [DW-1:0] dw, input bit drop, input bit scr);
      bit first_d;
      int n;
      int got;
      first_d = (wi && wd) ? !last_d : wd;
      push_exp(first_d, first_d ? dwr : 1'b0, first_d ? da : ia, dw);
      n = 1;
      if (wi && wd) begin
         push_exp(!first_d, !first_d ? dwr : 1'b0, !first_d ? da : ia, dw);
         n = 2;
      end
      bus.ic_addr  = ia;
      bus.dc_addr  = da;
      bus.dc_wdata = dw;
      bus.ic_read  = wi;
      bus.dc_read  = wd & drd;
      bus.dc_write = wd & dwr;
      @(negedge clk);
      check("req_to_strobe", 160'(bus.mem_read | bus.mem_write), 160'(1));
      if (first_d) begin
         if (drop) begin bus.dc_read = 1'b0; bus.dc_write = 1'b0; end
         if (scr)  begin bus.dc_addr = ~da; bus.dc_wdata = ~dw; end
      end else begin
         if (drop) bus.ic_read = 1'b0;
         if (scr)  bus.ic_addr = ~ia;
      end
      got = 0;
      for (int c = 0; c < 100 && got < n; c++) begin
         @(negedge clk);
         if (bus.ic_ready) begin bus.ic_read = 1'b0; got++; end
         if (bus.dc_ready) begin bus.dc_read = 1'b0; bus.dc_write = 1'b0; got++; end
      end
      check("completions", 160'(got), 160'(n));
      drop_all();
      @(negedge clk);
      check("back_to_idle", 160'({bus.mem_read, bus.mem_write, bus.ic_ready, bus.dc_ready}), 160'(0));
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached with %0d expectations pending", exp_q.size());
      $fatal(1, "watchdog");
   end

   initial begin
      int got;
      rst          = 1'b0;
      bus.ic_read  = 1'b0;
      bus.ic_addr  = '0;
      bus.dc_read  = 1'b0;
      bus.dc_write = 1'b0;
      bus.dc_addr  = '0;
      bus.dc_wdata = '0;
      mem_store[28'h0000010] = {16{8'hA5}};
      shadow[28'h0000010]    = {16{8'hA5}};

      apply_reset("reset");

      // Both caches held continuously from reset: D first, then alternating.
      for (int k = 0; k < 4; k++)
         push_exp(!last_d, 1'b0, !last_d ? 28'h0000200 : 28'h0000100, '0);
      bus.ic_addr = 28'h0000100;
      bus.dc_addr = 28'h0000200;
      bus.ic_read = 1'b1;
      bus.dc_read = 1'b1;
      @(negedge clk);
      check("alt_req_to_strobe", 160'(bus.mem_read), 160'(1));
      got = 0;
      for (int c = 0; c < 200 && got < 4; c++) begin
         @(negedge clk);
         if (bus.ic_ready || bus.dc_ready) got++;
         if (got == 4) drop_all();
      end
      check("alt_completions", 160'(got), 160'(4));
      drop_all();
      @(negedge clk);

      // mem_ready asserted with nothing outstanding must do nothing.
      glitch_all = 1'b1;
      repeat (4) begin
         @(negedge clk);
         check("idle_glitch", 160'({bus.mem_read, bus.mem_write, bus.ic_ready, bus.dc_ready}), 160'(0));
      end
      glitch_all = 1'b0;
      @(negedge clk);

      fixed_lat = 4;
      issue(1'b1, 1'b0, 1'b0, 1'b0, 28'h0000010, 28'h0, '0, 1'b0, 1'b0);
      fixed_lat = 3;
      issue(1'b0, 1'b1, 1'b0, 1'b1, 28'h0, 28'h0000020, 128'h1234, 1'b0, 1'b0);
      issue(1'b0, 1'b1, 1'b1, 1'b1, 28'h0, 28'h0000040, 128'hBEEF, 1'b0, 1'b0);

      // Reset while SERVE is waiting on memory, then mem_ready arrives.
      fixed_lat = 6;
      push_exp(1'b0, 1'b0, 28'h0000030, '0);
      bus.ic_addr = 28'h0000030;
      bus.ic_read = 1'b1;
      @(negedge clk);
      check("serve_before_reset", 160'(bus.mem_read), 160'(1));
      glitch_all = 1'b1;
      apply_reset("mid_serve_reset");
      repeat (3) begin
         @(negedge clk);
         check("post_reset_quiet", 160'({bus.mem_read, bus.mem_write, bus.ic_ready, bus.dc_ready}), 160'(0));
      end
      glitch_all = 1'b0;
      fixed_lat  = -1;
      @(negedge clk);
      issue(1'b1, 1'b1, 1'b1, 1'b0, 28'h0000050, 28'h0000060, '0, 1'b0, 1'b0);

      glitch_rand = 1'b1;
      for (int t = 0; t < 150; t++) begin
         int            mode;
         int            kind;
         logic [AW-1:0] ia;
         logic [AW-1:0] da;
         mode = $urandom_range(0, 2);
         kind = $urandom_range(0, 2);
         ia   = AW'($urandom_range(0, 15)) << 4;
         da   = AW'($urandom_range(0, 15)) << 4;
         issue(mode != 1, mode != 0, kind != 1, kind != 0, ia, da,
               {$urandom, $urandom, $urandom, $urandom},
               $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      end
      glitch_rand = 1'b0;
      repeat (2) @(negedge clk);
      check("queue_drained", 160'(exp_q.size()), 160'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
